// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, lamp codes, default phase durations and lamp decode helpers
package traffic_pkg;
   typedef enum logic [2:0] {NS_GRN, NS_YEL, RED_A, EW_GRN, EW_YEL, RED_B, PED_WALK, EMERG} phase_e;
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;
   localparam int DEF_WIDTH   = 6;
   localparam int DEF_GREEN_T = 20;
   localparam int DEF_YEL_T   = 3;
   localparam int DEF_RED_T   = 1;
   localparam int DEF_WALK_T  = 10;
   function automatic logic [2:0] ns_lamp(input phase_e p);
      return p == NS_GRN ? LT_GRN : p == NS_YEL ? LT_YEL : LT_RED;
   endfunction
   function automatic logic [2:0] ew_lamp(input phase_e p);
      return p == EW_GRN ? LT_GRN : p == EW_YEL ? LT_YEL : LT_RED;
   endfunction
endpackage

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: intersection phase sequencer timed by an external seconds timer
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int GREEN_T = DEF_GREEN_T,
   parameter int YEL_T   = DEF_YEL_T,
   parameter int RED_T   = DEF_RED_T,
   parameter int WALK_T  = DEF_WALK_T
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ped_req,
   input  logic             i_emergency,
   input  logic [WIDTH-1:0] i_timer_count,
   output logic             o_timer_start,
   output logic [2:0]       o_ns_light,
   output logic [2:0]       o_ew_light,
   output logic             o_walk,
   output logic             o_ped_pending
);
   phase_e           r_state, w_next;
   logic [2:0]       r_ns_light, r_ew_light;
   logic             r_walk, r_ped_pending;
   logic [WIDTH-1:0] w_lim;
   logic             w_exp;
   always_comb begin
      w_lim = r_state inside {NS_GRN, EW_GRN} ? WIDTH'(GREEN_T - 1) :
              r_state inside {NS_YEL, EW_YEL} ? WIDTH'(YEL_T - 1) :
              r_state == PED_WALK ? WIDTH'(WALK_T - 1) : WIDTH'(RED_T - 1);
      // >= rather than == so a count that ran past the limit still ends the phase
      w_exp = i_timer_count >= w_lim;
      w_next = r_state;
      case (r_state)
         NS_GRN:   if (w_exp || i_emergency) w_next = NS_YEL;
         NS_YEL:   if (w_exp) w_next = i_emergency ? EMERG : RED_A;
         RED_A:    if (w_exp) w_next = i_emergency ? EMERG : EW_GRN;
         EW_GRN:   if (w_exp || i_emergency) w_next = EW_YEL;
         EW_YEL:   if (w_exp) w_next = i_emergency ? EMERG : RED_B;
         RED_B:    if (w_exp) w_next = i_emergency ? EMERG : r_ped_pending ? PED_WALK : NS_GRN;
         PED_WALK: if (i_emergency) w_next = EMERG; else if (w_exp) w_next = NS_GRN;
         default:  if (!i_emergency) w_next = RED_A;
      endcase
      // timer is held cleared for the whole preempt so RED_A starts from zero
      o_timer_start = (w_next != r_state) || (r_state == EMERG);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= NS_GRN;
         r_ped_pending <= 1'b0;
         r_ns_light    <= LT_GRN;
         r_ew_light    <= LT_RED;
         r_walk        <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_ped_pending <= (w_next == PED_WALK && r_state != PED_WALK) ? 1'b0 : r_ped_pending | i_ped_req;
         r_ns_light    <= ns_lamp(w_next);
         r_ew_light    <= ew_lamp(w_next);
         r_walk        <= w_next == PED_WALK;
      end
   end
   assign o_ns_light    = r_ns_light;
   assign o_ew_light    = r_ew_light;
   assign o_walk        = r_walk;
   assign o_ped_pending = r_ped_pending;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed vector bench with a behavioural seconds timer beside the sequencer
module tb_traffic_phase_ctrl;
   localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
   logic       clk = 1'b0, rst_n = 1'b0, ped = 1'b0, em = 1'b0;
   logic       st, walk, pend;
   logic [5:0] cnt;
   logic [2:0] ns, ew;
   int         n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= 6'd0;
      else        cnt <= st ? 6'd0 : cnt + 6'd1;

   traffic_phase_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_ped_req(ped), .i_emergency(em), .i_timer_count(cnt),
      .o_timer_start(st), .o_ns_light(ns), .o_ew_light(ew), .o_walk(walk), .o_ped_pending(pend)
   );

   typedef struct {
      logic       ped, em;
      logic [2:0] ns, ew;
      logic       walk, pend, st;
   } vec_t;
   vec_t q[$];

   task automatic add(input logic p, e, input logic [2:0] ns_e, ew_e, input logic w, pd, s);
      vec_t v;
      v.ped = p; v.em = e; v.ns = ns_e; v.ew = ew_e; v.walk = w; v.pend = pd; v.st = s;
      q.push_back(v);
   endtask

   // n cycles of one phase, timer_start only on its last cycle
   task automatic ph(input logic [2:0] ns_e, ew_e, input logic w, pd, input int n, input logic e);
      for (int i = 0; i < n; i++) add(1'b0, e, ns_e, ew_e, w, pd, i == n - 1);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (ns ew walk pend start / count)", name, act, exp);
      end
   endtask

   task automatic run(input string tag);
      foreach (q[i]) begin
         ped = q[i].ped;
         em  = q[i].em;
         @(negedge clk);
         chk($sformatf("%s[%0d]", tag, i), {7'b0, ns, ew, walk, pend, st},
             {7'b0, q[i].ns, q[i].ew, q[i].walk, q[i].pend, q[i].st});
         @(posedge clk);
         #1;
      end
      ped = 1'b0;
      em  = 1'b0;
      q.delete();
   endtask

   always @(negedge clk)
      if (rst_n && !($onehot(ns) && $onehot(ew) && (ns == R || ew == R))) begin
         n_bad++;
         $display("FAIL lamp_safety: ns=%b ew=%b", ns, ew);
      end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // idle round
      ph(G, R, 0, 0, 20, 0); ph(Y, R, 0, 0, 3, 0); ph(R, R, 0, 0, 1, 0);
      ph(R, G, 0, 0, 20, 0); ph(R, Y, 0, 0, 3, 0); ph(R, R, 0, 0, 1, 0);
      // pedestrian pulse at cycle 5 of NS green
      for (int i = 0; i < 5; i++) add(0, 0, G, R, 0, 0, 0);
      add(1, 0, G, R, 0, 0, 0);
      for (int i = 0; i < 13; i++) add(0, 0, G, R, 0, 1, 0);
      add(0, 0, G, R, 0, 1, 1);
      ph(Y, R, 0, 1, 3, 0); ph(R, R, 0, 1, 1, 0); ph(R, G, 0, 1, 20, 0);
      ph(R, Y, 0, 1, 3, 0); ph(R, R, 0, 1, 1, 0); ph(R, R, 1, 0, 10, 0);
      // emergency at count 7 of NS green
      for (int i = 0; i < 7; i++) add(0, 0, G, R, 0, 0, 0);
      add(0, 1, G, R, 0, 0, 1);
      ph(Y, R, 0, 0, 3, 1);
      for (int i = 0; i < 15; i++) add(0, 1, R, R, 0, 0, 1);
      add(0, 0, R, R, 0, 0, 1);
      ph(R, R, 0, 0, 1, 0);
      // ped_req with emergency at count 4 of EW green
      for (int i = 0; i < 4; i++) add(0, 0, R, G, 0, 0, 0);
      add(1, 1, R, G, 0, 0, 1);
      ph(R, Y, 0, 1, 3, 1);
      for (int i = 0; i < 3; i++) add(0, 1, R, R, 0, 1, 1);
      add(0, 0, R, R, 0, 1, 1);
      ph(R, R, 0, 1, 1, 0); ph(R, G, 0, 1, 20, 0); ph(R, Y, 0, 1, 3, 0);
      ph(R, R, 0, 1, 1, 0); ph(R, R, 1, 0, 10, 0);
      // lead-in to count 12 of EW green
      ph(G, R, 0, 0, 20, 0); ph(Y, R, 0, 0, 3, 0); ph(R, R, 0, 0, 1, 0);
      for (int i = 0; i < 12; i++) add(0, 0, R, G, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {7'b0, ns, ew, walk, pend, st}, {7'b0, G, R, 3'b000});
      rst_n = 1'b1;
      run("vec");

      chk("pre_reset_ew_count", {7'b0, ew, cnt}, {7'b0, G, 6'd12});
      rst_n = 1'b0;
      #2;
      chk("async_reset", {7'b0, ns, ew, walk, pend, st}, {7'b0, G, R, 3'b000});
      chk("async_reset_timer", {10'b0, cnt}, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("held_reset", {7'b0, ns, ew, walk, pend, st}, {7'b0, G, R, 3'b000});
      rst_n = 1'b1;
      ph(G, R, 0, 0, 20, 0);
      add(0, 0, Y, R, 0, 0, 0);
      run("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
